data_sync_ctrl: RTL and testbench

DATA_SYNC_CTRL -- requirements
Module: data_sync_ctrl

---
 rtl/data_sync_ctrl.sv | 107 ++++++++++
 tb/tb_data_sync_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_ctrl.sv
// data_sync_ctrl
//   Brings a source-domain data bus into the CLK domain. The bus_enable
//   qualifier is synchronised through a flop chain. On a rising edge of the
//   synchronised qualifier, the bus is captured and a one-cycle strobe is
//   issued. The FSM then waits in HOLD for the qualifier to fall. If the
//   qualifier stays high for too long, a sticky error is raised.
//
// Ports
//   CLK          destination-domain clock, rising edge
//   RST          asynchronous reset, active high
//   EN           synchronous enable; all state holds while low except enable_pulse
//   bus_enable   unsynchronised qualifier, high marks Unsync_bus valid
//   Unsync_bus   source-domain data, stable while bus_enable is high
//   sync_bus     registered captured data
//   enable_pulse one-cycle strobe marking a new sync_bus value
//   busy         high while the FSM is in HOLD
//   capture_cnt  completed capture count, wraps at 256
//   stuck_err    sticky HOLD-timeout flag, cleared only by reset
module data_sync_ctrl #(
  parameter int unsigned NUM_STAGES   = 2,
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned HOLD_TIMEOUT = 1000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] Unsync_bus,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 busy,
  output logic [7:0]           capture_cnt,
  output logic                 stuck_err
);

  localparam logic [15:0] TIMEOUT = 16'(HOLD_TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] sync_chain;
  logic                  sync_en;
  logic                  sync_en_d;
  logic                  rise;
  logic                  fall;
  logic [15:0]           hold_cnt;
  logic [15:0]           hold_next;

  always_comb begin
    sync_en   = sync_chain[NUM_STAGES-1];
    rise      = sync_en & ~sync_en_d;
    fall      = ~sync_en & sync_en_d;
    hold_next = hold_cnt + 16'd1;
  end

  assign busy = (state == HOLD);

  // enable_pulse defaults low on every edge, so it drops even while EN is
  // low; everything else advances only on enabled edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      sync_chain   <= '0;
      sync_en_d    <= 1'b0;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      capture_cnt  <= '0;
      hold_cnt     <= '0;
      stuck_err    <= 1'b0;
    end else begin
      enable_pulse <= 1'b0;
      if (EN) begin
        sync_chain <= {sync_chain[NUM_STAGES-2:0], bus_enable};
        sync_en_d  <= sync_en;
        case (state)
          IDLE: begin
            if (rise) begin
              sync_bus     <= Unsync_bus;
              enable_pulse <= 1'b1;
              capture_cnt  <= capture_cnt + 8'd1;
              hold_cnt     <= '0;
              state        <= HOLD;
            end
          end
          HOLD: begin
            if (fall) begin
              state <= IDLE;
            end else if (hold_next == TIMEOUT) begin
              // Back in IDLE with the qualifier still high: sync_en_d is
              // already high, so no rise is seen until it drops and returns.
              stuck_err <= 1'b1;
              hold_cnt  <= '0;
              state     <= IDLE;
            end else begin
              hold_cnt <= hold_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_sync_ctrl.sv
module tb_data_sync_ctrl;

  localparam int unsigned NS = 2;
  localparam int unsigned TO = 10;
  localparam int unsigned BW = 8;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic          bus_enable;
  logic [BW-1:0] Unsync_bus;
  logic [BW-1:0] sync_bus;
  logic          enable_pulse;
  logic          busy;
  logic [7:0]    capture_cnt;
  logic          stuck_err;

  int tests  = 0;
  int failed = 0;

  data_sync_ctrl #(
    .NUM_STAGES  (NS),
    .BUS_WIDTH   (BW),
    .HOLD_TIMEOUT(TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .bus_enable  (bus_enable),
    .Unsync_bus  (Unsync_bus),
    .sync_bus    (sync_bus),
    .enable_pulse(enable_pulse),
    .busy        (busy),
    .capture_cnt (capture_cnt),
    .stuck_err   (stuck_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a history of enabled-edge samples of bus_enable,
  // edge detection on the NS-old sample, and a plain integer count of
  // enabled cycles spent waiting for the qualifier to fall.
  bit            hist[$];
  bit            m_prev;
  bit            m_waiting;
  int            m_wait;
  logic [BW-1:0] m_bus;
  bit            m_pulse;
  int            m_cap;
  bit            m_err;

  always @(posedge CLK or posedge RST) begin
    bit seen;
    if (RST) begin
      hist.delete();
      for (int i = 0; i < NS; i++) hist.push_back(1'b0);
      m_prev = 0; m_waiting = 0; m_wait = 0; m_bus = '0;
      m_pulse = 0; m_cap = 0; m_err = 0;
    end else begin
      m_pulse = 0;
      if (EN) begin
        seen = hist[NS-1];
        if (!m_waiting) begin
          if (seen && !m_prev) begin
            m_bus = Unsync_bus; m_pulse = 1; m_cap = (m_cap + 1) % 256;
            m_waiting = 1; m_wait = 0;
          end
        end else if (!seen && m_prev) begin
          m_waiting = 0;
        end else begin
          m_wait = m_wait + 1;
          if (m_wait == TO) begin
            m_err = 1; m_wait = 0; m_waiting = 0;
          end
        end
        m_prev = seen;
        hist.push_front(bus_enable);
        void'(hist.pop_back());
      end
    end
  end

  always @(negedge CLK) begin
    check("sync_bus",     32'(sync_bus),     32'(m_bus));
    check("enable_pulse", 32'(enable_pulse), 32'(m_pulse));
    check("busy",         32'(busy),         32'(m_waiting));
    check("capture_cnt",  32'(capture_cnt),  32'(m_cap));
    check("stuck_err",    32'(stuck_err),    32'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; bus_enable = 1'b0; Unsync_bus = '0;
    tick(2);
    check("rst_sync_bus", 32'(sync_bus), 32'h0);
    check("rst_cnt",      32'(capture_cnt), 32'h0);
    check("rst_busy",     32'(busy), 32'h0);
    RST = 1'b0;

    // First capture: pulse after the third edge.
    Unsync_bus = 8'hA5; bus_enable = 1'b1;
    tick(2);
    check("t1_no_early_pulse", 32'(enable_pulse), 32'h0);
    tick(1);
    check("t1_pulse", 32'(enable_pulse), 32'h1);
    check("t1_bus",   32'(sync_bus), 32'hA5);
    check("t1_cnt",   32'(capture_cnt), 32'h1);
    check("t1_busy",  32'(busy), 32'h1);

    // Four low cycles, then a second capture.
    bus_enable = 1'b0;
    tick(4);
    check("t2_idle", 32'(busy), 32'h0);
    Unsync_bus = 8'h3C; bus_enable = 1'b1;
    tick(2);
    check("t2_no_early_pulse", 32'(enable_pulse), 32'h0);
    check("t2_bus_held",       32'(sync_bus), 32'hA5);
    tick(1);
    check("t2_pulse", 32'(enable_pulse), 32'h1);
    check("t2_bus",   32'(sync_bus), 32'h3C);
    check("t2_cnt",   32'(capture_cnt), 32'h2);

    // Level kept high: timeout ten enabled cycles after capture.
    tick(9);
    check("t3_before_to_busy", 32'(busy), 32'h1);
    check("t3_before_to_err",  32'(stuck_err), 32'h0);
    tick(1);
    check("t3_err",  32'(stuck_err), 32'h1);
    check("t3_busy", 32'(busy), 32'h0);
    tick(5);
    check("t3_no_recapture", 32'(capture_cnt), 32'h2);
    bus_enable = 1'b0;
    tick(3);
    Unsync_bus = 8'h5A; bus_enable = 1'b1;
    tick(3);
    check("t3_recapture_pulse", 32'(enable_pulse), 32'h1);
    check("t3_recapture_bus",   32'(sync_bus), 32'h5A);
    check("t3_cnt",             32'(capture_cnt), 32'h3);
    check("t3_err_sticky",      32'(stuck_err), 32'h1);

    // EN stall of five cycles in the middle of synchronisation.
    bus_enable = 1'b0;
    tick(4);
    Unsync_bus = 8'hC3; bus_enable = 1'b1;
    tick(1);
    EN = 1'b0;
    tick(5);
    check("t4_stall_no_pulse", 32'(enable_pulse), 32'h0);
    check("t4_stall_bus",      32'(sync_bus), 32'h5A);
    EN = 1'b1;
    tick(1);
    check("t4_no_early_pulse", 32'(enable_pulse), 32'h0);
    tick(1);
    check("t4_pulse", 32'(enable_pulse), 32'h1);
    check("t4_bus",   32'(sync_bus), 32'hC3);
    check("t4_cnt",   32'(capture_cnt), 32'h4);
    EN = 1'b0;
    tick(1);
    check("t4_pulse_drops_en0", 32'(enable_pulse), 32'h0);
    check("t4_busy_en0",        32'(busy), 32'h1);
    tick(2);
    EN = 1'b1;
    bus_enable = 1'b0;
    tick(4);

    // Reset in the middle of HOLD, qualifier still high afterwards.
    Unsync_bus = 8'h77; bus_enable = 1'b1;
    tick(3);
    check("t5_cnt", 32'(capture_cnt), 32'h5);
    tick(2);
    #2 RST = 1'b1;
    #1;
    check("t5_rst_bus",  32'(sync_bus), 32'h0);
    check("t5_rst_cnt",  32'(capture_cnt), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_err",  32'(stuck_err), 32'h0);
    check("t5_rst_pulse", 32'(enable_pulse), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    tick(2);
    check("t5_no_early_pulse", 32'(enable_pulse), 32'h0);
    tick(1);
    check("t5_pulse", 32'(enable_pulse), 32'h1);
    check("t5_bus",   32'(sync_bus), 32'h77);
    check("t5_cnt1",  32'(capture_cnt), 32'h1);
    tick(1);
    check("t5_single_pulse", 32'(enable_pulse), 32'h0);

    // Wrap: 255 more captures bring the count from 1 back to 0.
    bus_enable = 1'b0;
    tick(3);
    for (int i = 0; i < 255; i++) begin
      Unsync_bus = 8'(i); bus_enable = 1'b1;
      tick(3);
      bus_enable = 1'b0;
      tick(3);
    end
    check("t6_wrap_cnt", 32'(capture_cnt), 32'h0);
    check("t6_last_bus", 32'(sync_bus), 32'hFE);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
